// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-to-read bypass and a per-register
// busy scoreboard for destination reservations (WAW stall), plus a count
// of outstanding reservations. Register 0 is hardwired to zero and never busy.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWrite,
    input  logic [AW-1:0]   Rd,
    input  logic [XLEN-1:0] Write_data,
    input  logic [AW-1:0]   Rs1,
    input  logic [AW-1:0]   Rs2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     pending_cnt
);

    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic wb_en;
    logic issue_set;
    logic cnt_inc;
    logic cnt_dec;

    // Writeback/reservation qualifiers and count deltas; a writeback that
    // meets an accepted reservation on the same index leaves busy set, so
    // it must not decrement the count.
    always_comb begin
        wb_en       = RegWrite && (Rd != '0);
        issue_ready = (issue_rd == '0) || !busy[issue_rd] || (RegWrite && (Rd == issue_rd));
        issue_set   = issue_valid && issue_ready && (issue_rd != '0);
        cnt_inc     = issue_set && !busy[issue_rd];
        cnt_dec     = wb_en && busy[Rd] && !(issue_set && (issue_rd == Rd));
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        read_data1 = regs[Rs1];
        read_data2 = regs[Rs2];
        rs1_busy   = busy[Rs1];
        rs2_busy   = busy[Rs2];
        if ((BYPASS != 0) && wb_en && (Rd == Rs1)) begin
            read_data1 = Write_data;
            rs1_busy   = 1'b0;
        end
        if ((BYPASS != 0) && wb_en && (Rd == Rs2)) begin
            read_data2 = Write_data;
            rs2_busy   = 1'b0;
        end
        if (Rs1 == '0) begin
            read_data1 = '0;
            rs1_busy   = 1'b0;
        end
        if (Rs2 == '0) begin
            read_data2 = '0;
            rs2_busy   = 1'b0;
        end
    end

    // Register storage; index 0 is only ever cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[Rd] <= Write_data;
        end
    end

    // Busy scoreboard; the set follows the clear so a new reservation wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (wb_en) begin
                busy[Rd] <= 1'b0;
            end
            if (issue_set) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    // Registered count of outstanding reservations, tracked incrementally.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_cnt <= '0;
        end else begin
            pending_cnt <= pending_cnt + (AW + 1)'(cnt_inc) - (AW + 1)'(cnt_dec);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an
// array-based behavioural model of registers and reservations.
module tb_regfile_sb;

    localparam int XLEN   = 32;
    localparam int AW     = 5;
    localparam int BYPASS = 1;
    localparam int NREG   = 2 ** AW;

    logic            clk;
    logic            reset;
    logic            RegWrite;
    logic [AW-1:0]   Rd;
    logic [XLEN-1:0] Write_data;
    logic [AW-1:0]   Rs1;
    logic [AW-1:0]   Rs2;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [AW:0]     pending_cnt;

    regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .Rd(Rd),
        .Write_data(Write_data), .Rs1(Rs1), .Rs2(Rs2),
        .read_data1(read_data1), .read_data2(read_data2),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    logic [XLEN-1:0] mregs [NREG];
    bit              mbusy [NREG];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        if (BYPASS != 0 && RegWrite && Rd == rs) return Write_data;
        return mregs[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs);
        if (rs == 0) return 1'b0;
        if (BYPASS != 0 && RegWrite && Rd == rs) return 1'b0;
        return mbusy[rs];
    endfunction

    function automatic logic exp_ready();
        return (issue_rd == 0) || !mbusy[issue_rd] || (RegWrite && Rd == issue_rd);
    endfunction

    function automatic int exp_pending();
        int n = 0;
        for (int i = 0; i < NREG; i++) if (mbusy[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        reset = 1'b0; RegWrite = 1'b0; Rd = '0; Write_data = '0;
        Rs1 = '0; Rs2 = '0; issue_valid = 1'b0; issue_rd = '0;
    endtask

    // Check all outputs against the model, then clock one edge and advance the model.
    task automatic cycle(input string tag);
        bit acc;
        #1;
        chk({tag, ":rd1"},     64'(read_data1),  64'(exp_read(Rs1)));
        chk({tag, ":rd2"},     64'(read_data2),  64'(exp_read(Rs2)));
        chk({tag, ":rs1busy"}, 64'(rs1_busy),    64'(exp_busy(Rs1)));
        chk({tag, ":rs2busy"}, 64'(rs2_busy),    64'(exp_busy(Rs2)));
        chk({tag, ":ready"},   64'(issue_ready), 64'(exp_ready()));
        chk({tag, ":pending"}, 64'(pending_cnt), 64'(exp_pending()));
        acc = issue_valid && exp_ready();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (RegWrite && Rd != 0) begin
                mregs[Rd] = Write_data;
                mbusy[Rd] = 1'b0;
            end
            if (acc && issue_rd != 0) mbusy[issue_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        idle();

        // Reset state
        Rs1 = 3; Rs2 = 0;
        #1;
        chk("r039_rd1", 64'(read_data1), 64'h0);
        chk("r039_rd2", 64'(read_data2), 64'h0);
        chk("r039_pend", 64'(pending_cnt), 64'h0);
        chk("r039_ready", 64'(issue_ready), 64'h1);
        cycle("r039");

        // Write with same-cycle read
        idle(); RegWrite = 1; Rd = 5; Write_data = 32'hDEADBEEF; Rs1 = 5;
        #1;
        chk("r040_byp", 64'(read_data1), (BYPASS != 0) ? 64'hDEADBEEF : 64'h0);
        cycle("r040a");
        idle(); Rs1 = 5;
        #1;
        chk("r040_next", 64'(read_data1), 64'hDEADBEEF);
        cycle("r040b");

        // Register 0
        idle(); RegWrite = 1; Rd = 0; Write_data = 32'h1234; issue_valid = 1; issue_rd = 0;
        cycle("r041a");
        idle();
        #1;
        chk("r041_rd1", 64'(read_data1), 64'h0);
        chk("r041_pend", 64'(pending_cnt), 64'h0);
        cycle("r041b");

        // WAW stall on x7, then writeback
        idle(); issue_valid = 1; issue_rd = 7;
        cycle("r042a");
        #1;
        chk("r042_ready", 64'(issue_ready), 64'h0);
        cycle("r042b");
        idle(); Rs1 = 7;
        #1;
        chk("r042_pend", 64'(pending_cnt), 64'h1);
        chk("r042_busy", 64'(rs1_busy), 64'h1);
        cycle("r042c");
        idle(); RegWrite = 1; Rd = 7; Write_data = 9;
        cycle("r042d");
        idle(); Rs1 = 7;
        #1;
        chk("r042a_pend", 64'(pending_cnt), 64'h0);
        chk("r042a_busy", 64'(rs1_busy), 64'h0);
        chk("r042a_rd1", 64'(read_data1), 64'h9);
        cycle("r042e");

        // Same-edge issue and writeback on busy x9
        idle(); issue_valid = 1; issue_rd = 9;
        cycle("r043a");
        idle(); issue_valid = 1; issue_rd = 9; RegWrite = 1; Rd = 9; Write_data = 32'h55;
        #1;
        chk("r043_ready", 64'(issue_ready), 64'h1);
        cycle("r043b");
        idle(); Rs1 = 9;
        #1;
        chk("r043_pend", 64'(pending_cnt), 64'h1);
        chk("r043_busy", 64'(rs1_busy), 64'h1);
        chk("r043_rd1", 64'(read_data1), 64'h55);
        cycle("r043c");
        idle(); RegWrite = 1; Rd = 9; Write_data = 32'h55;
        cycle("r043d");

        // Reservations dropped by reset mid-sequence
        for (int i = 1; i <= 4; i++) begin
            idle(); issue_valid = 1; issue_rd = AW'(i);
            cycle("r044_iss");
        end
        idle();
        #1;
        chk("r044_pend4", 64'(pending_cnt), 64'h4);
        cycle("r044_chk");
        idle(); reset = 1; issue_valid = 1; issue_rd = 5; RegWrite = 1; Rd = 6; Write_data = 32'hABCD;
        cycle("r044_rst");
        idle(); RegWrite = 1; Rd = 2; Write_data = 7;
        cycle("r044_wb");
        idle(); Rs1 = 2; Rs2 = 6;
        #1;
        chk("r044_pend", 64'(pending_cnt), 64'h0);
        chk("r044_busy", 64'(rs1_busy), 64'h0);
        chk("r044_rd1", 64'(read_data1), 64'h7);
        chk("r044_rd2", 64'(read_data2), 64'h0);
        cycle("r044_end");

        // Random traffic concentrated on few indices to force collisions
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            RegWrite    = $urandom_range(0, 1);
            Rd          = AW'($urandom_range(0, 7));
            Write_data  = $urandom;
            Rs1         = AW'($urandom_range(0, 7));
            Rs2         = AW'($urandom_range(0, 7));
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_rd    = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
